// File: rtl/floo_route_encode.sv
// floo_route_encode -- source-routing header encoder at the NI injection point.
//
// Purpose:
//   Looks up hdr.dst_id (low DstIdxWidth bits) in a runtime-programmable route
//   table and replaces hdr.dst_id with the packed per-hop port selections
//   (hop 0 in the LSBs, zero-extended). The route is locked at the packet
//   head and reused for every following flit up to and including hdr.last.
//   Packets whose head hits an invalid entry are accepted and discarded,
//   with a one-cycle err_o pulse. The output passes one registered
//   valid/ready stage.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cfg_we_i/cfg_idx_i/
//   cfg_route_i/cfg_valid_i route-table write port (takes effect next cycle)
//   valid_i/ready_o/channel_i  input flit handshake
//   valid_o/ready_i/channel_o  encoded output flit handshake
//   err_o                   one-cycle pulse per dropped packet
//   err_cnt_o               saturating dropped-packet count, only when the
//                           macro FLOO_ROUTE_ENC_ERR_CNT_EN is defined

package floo_route_encode_pkg;
    typedef struct packed {
        logic [15:0] dst_id;
        logic [7:0]  src_id;
        logic        last;
    } hdr_t;

    typedef struct packed {
        hdr_t        hdr;
        logic [31:0] payload;
    } flit_t;
endpackage

module floo_route_encode #(
    parameter int unsigned NumRoutes     = 5,
    parameter int unsigned RouteSelWidth = $clog2(NumRoutes),
    parameter int unsigned MaxHops       = 4,
    parameter int unsigned NumDst        = 16,
    parameter int unsigned DstIdxWidth   = $clog2(NumDst),
    parameter type         flit_t        = floo_route_encode_pkg::flit_t,
    localparam int unsigned RouteWidth   = MaxHops * RouteSelWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_we_i,
    input  logic [DstIdxWidth-1:0] cfg_idx_i,
    input  logic [RouteWidth-1:0]  cfg_route_i,
    input  logic                   cfg_valid_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  flit_t                  channel_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output flit_t                  channel_o,
    output logic                   err_o
`ifdef FLOO_ROUTE_ENC_ERR_CNT_EN
    ,
    output logic [15:0]            err_cnt_o
`endif
);

    localparam int unsigned DstIdBits = $bits(channel_i.hdr.dst_id);

    if (DstIdBits < RouteWidth) begin : g_width_check
        $fatal(1, "floo_route_encode: hdr.dst_id narrower than RouteWidth");
    end

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_e;

    state_e                  state_q;
    logic                    valid_q;
    flit_t                   data_q;
    logic                    err_q;
    logic [RouteWidth-1:0]   route_q;

    // Route table: route bits need no reset, only the valid bits do.
    logic [RouteWidth-1:0]   route_mem [NumDst];
    logic                    tbl_valid_q [NumDst];

    logic [DstIdxWidth-1:0]  lookup_idx;
    logic                    lookup_in_range;
    logic                    cfg_in_range;
    logic                    lookup_hit;
    logic [RouteWidth-1:0]   lookup_route;
    logic [RouteWidth-1:0]   sel_route;
    flit_t                   enc_flit;
    logic                    accept;
    logic                    drop_head;

    assign lookup_idx = channel_i.hdr.dst_id[DstIdxWidth-1:0];

    // When the table fills the whole index space every index is in range;
    // only a non-power-of-two table needs the explicit bound check.
    if (NumDst == (1 << DstIdxWidth)) begin : g_full_range
        assign lookup_in_range = 1'b1;
        assign cfg_in_range    = 1'b1;
    end else begin : g_part_range
        assign lookup_in_range = (32'(lookup_idx) < NumDst);
        assign cfg_in_range    = (32'(cfg_idx_i) < NumDst);
    end

    assign ready_o = !rst_i && (!valid_q || ready_i);
    assign accept  = valid_i && ready_o;

    // Lookup reads the table before this cycle's write lands, so a write and
    // a head lookup of the same index in one cycle see the old entry.
    always_comb begin
        lookup_route = '0;
        lookup_hit   = 1'b0;
        if (lookup_in_range) begin
            lookup_route = route_mem[lookup_idx];
            lookup_hit   = tbl_valid_q[lookup_idx];
        end
        sel_route = (state_q == FWD) ? route_q : lookup_route;
        enc_flit  = channel_i;
        enc_flit.hdr.dst_id = '0;
        enc_flit.hdr.dst_id[RouteWidth-1:0] = sel_route;
    end

    assign drop_head = accept && (state_q == IDLE) && !lookup_hit;

    always_ff @(posedge clk_i) begin
        if (cfg_we_i && cfg_in_range) begin
            route_mem[cfg_idx_i] <= cfg_route_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumDst); i++) begin
                tbl_valid_q[i] <= 1'b0;
            end
        end else if (cfg_we_i && cfg_in_range) begin
            tbl_valid_q[cfg_idx_i] <= cfg_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            route_q <= '0;
        end else begin
            err_q <= 1'b0;
            // Output slot drains on a downstream handshake; a new accept below
            // may refill it in the same cycle.
            if (ready_i) begin
                valid_q <= 1'b0;
            end
            if (accept) begin
                unique case (state_q)
                    IDLE: begin
                        if (lookup_hit) begin
                            route_q <= lookup_route;
                            valid_q <= 1'b1;
                            data_q  <= enc_flit;
                            if (!channel_i.hdr.last) state_q <= FWD;
                        end else begin
                            err_q <= 1'b1;
                            if (!channel_i.hdr.last) state_q <= DROP;
                        end
                    end
                    FWD: begin
                        valid_q <= 1'b1;
                        data_q  <= enc_flit;
                        if (channel_i.hdr.last) state_q <= IDLE;
                    end
                    DROP: begin
                        if (channel_i.hdr.last) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef FLOO_ROUTE_ENC_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Counts at the same edge that raises err_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else if (drop_head && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    logic unused_drop_head;
    assign unused_drop_head = drop_head;
`endif

    assign valid_o   = valid_q;
    assign channel_o = data_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_floo_route_encode.sv
module tb_floo_route_encode;
    import floo_route_encode_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cfg_we_i;
    logic [3:0]  cfg_idx_i;
    logic [11:0] cfg_route_i;
    logic        cfg_valid_i;
    logic        valid_i;
    logic        ready_o;
    flit_t       channel_i;
    logic        valid_o;
    logic        ready_i;
    flit_t       channel_o;
    logic        err_o;
`ifdef FLOO_ROUTE_ENC_ERR_CNT_EN
    logic [15:0] err_cnt_o;
`endif

    floo_route_encode dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_idx_i   (cfg_idx_i),
        .cfg_route_i (cfg_route_i),
        .cfg_valid_i (cfg_valid_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .channel_i   (channel_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .channel_o   (channel_o),
        .err_o       (err_o)
`ifdef FLOO_ROUTE_ENC_ERR_CNT_EN
        ,
        .err_cnt_o   (err_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: route table, per-packet lock, expected output queue.
    logic [11:0] m_route_tbl [16];
    bit          m_valid_tbl [16];
    bit          m_in_pkt;
    bit          m_drop;
    logic [11:0] m_route;
    flit_t       exp_q [$];
    bit          exp_err;
    int          m_cnt;
    bit          prev_stall;
    flit_t       prev_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid_tbl[i] = 1'b0;
        m_in_pkt = 1'b0;
        m_drop = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        m_cnt = 0;
        prev_stall = 1'b0;
    endtask

    task automatic model_accept(input flit_t f);
        flit_t o;
        int idx;
        idx = int'(f.hdr.dst_id[3:0]);
        if (!m_in_pkt) begin
            if (m_valid_tbl[idx]) begin
                m_route = m_route_tbl[idx];
                m_drop = 1'b0;
            end else begin
                m_drop = 1'b1;
                exp_err = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end
        end
        if (!m_drop) begin
            o = f;
            o.hdr.dst_id = {4'h0, m_route};
            exp_q.push_back(o);
        end
        m_in_pkt = !f.hdr.last;
    endtask

    function automatic flit_t mk_flit(input logic [15:0] dst, input logic last);
        flit_t f;
        f.hdr.dst_id = dst;
        f.hdr.src_id = 8'($urandom);
        f.hdr.last   = last;
        f.payload    = $urandom;
        return f;
    endfunction

    // One clock cycle: drive at posedge+1, check at negedge, model at next posedge.
    task automatic cycle(input logic v, input flit_t f, input logic rdy,
                         input logic we, input logic [3:0] widx,
                         input logic [11:0] wroute, input logic wval,
                         output logic hs);
        logic pop;
        valid_i = v; channel_i = f; ready_i = rdy;
        cfg_we_i = we; cfg_idx_i = widx; cfg_route_i = wroute; cfg_valid_i = wval;
        @(negedge clk_i);
        chk("ready_rule", 64'(ready_o), 64'(!(valid_o && !rdy)));
        chk("valid_vs_model", 64'(valid_o), 64'(exp_q.size() != 0));
        if (valid_o && exp_q.size() != 0) chk("data_vs_model", 64'(channel_o), 64'(exp_q[0]));
        chk("err_vs_model", 64'(err_o), 64'(exp_err));
`ifdef FLOO_ROUTE_ENC_ERR_CNT_EN
        chk("err_cnt", 64'(err_cnt_o), 64'(m_cnt));
`endif
        if (prev_stall) begin
            chk("stall_valid_hold", 64'(valid_o), 64'd1);
            chk("stall_data_hold", 64'(channel_o), 64'(prev_data));
        end
        prev_stall = valid_o && !rdy;
        prev_data  = channel_o;
        hs  = v && ready_o;
        pop = valid_o && rdy;
        if (pop) $display("xfer dst_id=%h src=%h last=%b payload=%h",
                          channel_o.hdr.dst_id, channel_o.hdr.src_id, channel_o.hdr.last, channel_o.payload);
        @(posedge clk_i);
        #1;
        if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
        exp_err = 1'b0;
        if (hs) model_accept(f);
        if (we) begin
            m_route_tbl[widx] = wroute;
            m_valid_tbl[widx] = wval;
        end
    endtask

    task automatic idle(input int n);
        logic hs;
        flit_t z;
        z = '0;
        for (int i = 0; i < n; i++) cycle(1'b0, z, 1'b1, 1'b0, 4'h0, 12'h0, 1'b0, hs);
    endtask

    task automatic prog(input logic [3:0] idx, input logic [11:0] route, input logic val);
        logic hs;
        flit_t z;
        z = '0;
        cycle(1'b0, z, 1'b1, 1'b1, idx, route, val, hs);
    endtask

    task automatic send(input logic [15:0] dst, input logic last, output flit_t f, output logic hs);
        f = mk_flit(dst, last);
        cycle(1'b1, f, 1'b1, 1'b0, 4'h0, 12'h0, 1'b0, hs);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        valid_i = 1'b1;
        ready_i = 1'b0;
        cfg_we_i = 1'b0;
        @(negedge clk_i);
        chk("reset_ready", 64'(ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        chk("reset_valid", 64'(valid_o), 64'd0);
        chk("reset_err", 64'(err_o), 64'd0);
        chk("reset_channel", 64'(channel_o), 64'd0);
`ifdef FLOO_ROUTE_ENC_ERR_CNT_EN
        chk("reset_err_cnt", 64'(err_cnt_o), 64'd0);
`endif
        model_clear();
        rst_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  prog_idx;
        logic [11:0] prog_route;
        logic        prog_v;
        logic [15:0] dst;
        logic        exp_fwd;
        logic [11:0] exp_route;
    } vec_t;

    initial begin
        vec_t  vecs [6];
        flit_t f;
        flit_t bp [8];
        logic  hs;
        int    n_err;
        int    sent;
        int    guard;
        logic  pat [4];

        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; channel_i = '0;
        cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_route_i = '0; cfg_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) m_route_tbl[i] = '0;
        model_clear();
        @(posedge clk_i);
        #1;
        do_reset();

        // Single-flit table vectors.
        vecs[0] = '{4'd2,  12'h321, 1'b1, 16'h0002, 1'b1, 12'h321};
        vecs[1] = '{4'd7,  12'h000, 1'b0, 16'h0007, 1'b0, 12'h000};
        vecs[2] = '{4'd4,  12'hABC, 1'b1, 16'hFFF4, 1'b1, 12'hABC};
        vecs[3] = '{4'd15, 12'h444, 1'b1, 16'h000F, 1'b1, 12'h444};
        vecs[4] = '{4'd0,  12'hFFF, 1'b1, 16'h0010, 1'b1, 12'hFFF};
        vecs[5] = '{4'd9,  12'h123, 1'b0, 16'h0009, 1'b0, 12'h000};
        for (int i = 0; i < 6; i++) begin
            prog(vecs[i].prog_idx, vecs[i].prog_route, vecs[i].prog_v);
            send(vecs[i].dst, 1'b1, f, hs);
            chk($sformatf("vec%0d_accept", i), 64'(hs), 64'd1);
            chk($sformatf("vec%0d_valid", i), 64'(valid_o), 64'(vecs[i].exp_fwd));
            chk($sformatf("vec%0d_err", i), 64'(err_o), 64'(!vecs[i].exp_fwd));
            if (vecs[i].exp_fwd) begin
                chk($sformatf("vec%0d_dst", i), 64'(channel_o.hdr.dst_id), 64'({4'h0, vecs[i].exp_route}));
                chk($sformatf("vec%0d_payload", i), 64'(channel_o.payload), 64'(f.payload));
                chk($sformatf("vec%0d_src", i), 64'(channel_o.hdr.src_id), 64'(f.hdr.src_id));
            end
            idle(1);
        end

        // Multi-flit lock.
        prog(4'd5, 12'h0A4, 1'b1);
        send(16'h0002, 1'b0, f, hs);
        chk("lock_f0", 64'(channel_o.hdr.dst_id), 64'h321);
        send(16'h0005, 1'b0, f, hs);
        chk("lock_f1", 64'(channel_o.hdr.dst_id), 64'h321);
        send(16'h0005, 1'b1, f, hs);
        chk("lock_f2", 64'(channel_o.hdr.dst_id), 64'h321);
        send(16'h0005, 1'b1, f, hs);
        chk("lock_next_pkt", 64'(channel_o.hdr.dst_id), 64'h0A4);
        idle(1);

        // Drop a 4-flit packet to unprogrammed idx 7.
        n_err = 0;
        for (int i = 0; i < 4; i++) begin
            send(16'h0007, (i == 3), f, hs);
            chk("drop_accept", 64'(hs), 64'd1);
            chk("drop_no_valid", 64'(valid_o), 64'd0);
            if (err_o) n_err++;
        end
        idle(1);
        chk("drop_err_pulses", 64'(n_err), 64'd1);

        // Same-cycle write and head lookup: lookup sees the old (invalid) entry.
        f = mk_flit(16'h0006, 1'b1);
        cycle(1'b1, f, 1'b1, 1'b1, 4'd6, 12'h555, 1'b1, hs);
        chk("wr_lookup_old_valid", 64'(valid_o), 64'd0);
        chk("wr_lookup_old_err", 64'(err_o), 64'd1);
        send(16'h0006, 1'b1, f, hs);
        chk("wr_lookup_new", 64'(channel_o.hdr.dst_id), 64'h555);
        idle(1);

        // Backpressure: ready pattern 1,0,0,1.
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int i = 0; i < 8; i++) bp[i] = mk_flit((i % 2) ? 16'h0002 : 16'h0004, 1'b1);
        sent = 0;
        guard = 0;
        while (sent < 8 && guard < 100) begin
            cycle(1'b1, bp[sent], pat[guard % 4], 1'b0, 4'h0, 12'h0, 1'b0, hs);
            if (hs) sent++;
            guard++;
        end
        chk("bp_all_sent", 64'(sent), 64'd8);
        idle(2);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Mid-packet rewrite.
        prog(4'd3, 12'h111, 1'b1);
        send(16'h0003, 1'b0, f, hs);
        chk("rw_f0", 64'(channel_o.hdr.dst_id), 64'h111);
        send(16'h0003, 1'b0, f, hs);
        chk("rw_f1", 64'(channel_o.hdr.dst_id), 64'h111);
        f = mk_flit(16'h0003, 1'b0);
        cycle(1'b1, f, 1'b1, 1'b1, 4'd3, 12'h222, 1'b1, hs);
        chk("rw_f2", 64'(channel_o.hdr.dst_id), 64'h111);
        send(16'h0003, 1'b1, f, hs);
        chk("rw_f3", 64'(channel_o.hdr.dst_id), 64'h111);
        send(16'h0003, 1'b1, f, hs);
        chk("rw_next_pkt", 64'(channel_o.hdr.dst_id), 64'h222);
        idle(1);

        // Reset mid-packet with a pending output flit.
        send(16'h0002, 1'b0, f, hs);
        f = mk_flit(16'h0002, 1'b0);
        cycle(1'b1, f, 1'b0, 1'b0, 4'h0, 12'h0, 1'b0, hs);
        chk("rst_pending", 64'(valid_o), 64'd1);
        do_reset();
        prog(4'd2, 12'h321, 1'b1);
        prog(4'd5, 12'h0A4, 1'b1);
        send(16'h0005, 1'b1, f, hs);
        chk("rst_head", 64'(channel_o.hdr.dst_id), 64'h0A4);
        send(16'h0002, 1'b1, f, hs);
        chk("rst_head2", 64'(channel_o.hdr.dst_id), 64'h321);
        idle(1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            f = mk_flit(16'($urandom), ($urandom_range(0, 2) == 0));
            cycle(($urandom_range(0, 3) != 0), f, ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 7) == 0), 4'($urandom), 12'($urandom),
                  ($urandom_range(0, 3) != 0), hs);
        end
        idle(3);
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
